tecmo_sdram_arbiter: RTL and testbench
======================================

# tecmo_sdram_arbiter

Shares the single `sdram` controller port (23-bit word address, 32-bit data, req/ack/valid handshake) between four requesters: ROM download, main CPU ROM, sound CPU ROM and graphics tile fetch. It sits between the game core's memory clients and the `sdram` instance, above the controller and below the clients. It grants one transaction at a time, latches that transaction's request, and routes the controller's ack/valid back to the owning port. While a ROM download is in progress, only the download port is served.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of requester ports; port 0 is always the download (write-capable) port.
- `ADDR_WIDTH`, 23, SDRAM word address width.
- `DATA_WIDTH`, 32, SDRAM data width.

Ports:
- `clk` in 1: system clock (48 MHz).
- `reset` in 1: asynchronous, active-high.
- `download` in 1: ROM download active; locks the grant to port 0.
- `port_addr` in NUM_PORTS×ADDR_WIDTH: per-port word address.
- `port_data` in NUM_PORTS×DATA_WIDTH: per-port write data; used for port 0 only.
- `port_we` in NUM_PORTS: per-port write enable; ignored for ports 1..3.
- `port_req` in NUM_PORTS: per-port request level, held until that port's ack.
- `port_ack` out NUM_PORTS: one-cycle pulse; the request was accepted by the controller.
- `port_valid` out NUM_PORTS: one-cycle pulse; read data is on `port_q`.
- `port_q` out DATA_WIDTH: read data, broadcast to all ports.
- `sdram_addr` out ADDR_WIDTH, `sdram_data` out DATA_WIDTH, `sdram_we` out 1, `sdram_req` out 1: controller request.
- `sdram_ack` in 1, `sdram_valid` in 1, `sdram_q` in DATA_WIDTH: controller response.

## Operation
- FSM states: IDLE, REQ, WAIT_VALID.
- IDLE, eligible set non-empty: register `grant`; latch the granted port's addr, data and we; go to REQ.
  - The eligible set is {0} when `download`=1.
  - Otherwise it is every port with `port_req` set. Port 0 is included only if `port_we` is set or its request is a read.
- REQ: `sdram_req`=1 with the latched fields.
  - On `sdram_ack`: pulse `port_ack[grant]`.
  - If write: go to IDLE.
  - If read: go to WAIT_VALID. If `sdram_valid` arrives in the same cycle as `sdram_ack`, pulse `port_valid[grant]` and go to IDLE.
- WAIT_VALID: on `sdram_valid`, pulse `port_valid[grant]` and go to IDLE.
- `port_q` = `sdram_q`, passed through combinationally.
- `port_ack[i]` = `sdram_ack` & state==REQ & grant==i. `port_valid` is formed the same way from `sdram_valid`.
- `download` rising while a read is in flight: the in-flight read completes normally. Pending reads on ports 1..3 are then starved until `download` falls.
- A requester that drops `port_req` before its ack does not alter the issued transaction, because the fields are latched. The ack is still pulsed.
- `sdram_ack` or `sdram_valid` arriving in IDLE is ignored; no port pulse is generated.

## Timing
- Reset values: state IDLE, `grant`=0, `sdram_req`=0, `sdram_we`=0, `sdram_addr`=0, `sdram_data`=0, `port_ack`=0, `port_valid`=0.
- Request latency: `port_req` sampled high in IDLE at cycle N gives `sdram_req` high at cycle N+1.
- `sdram_req` stays high until and including the cycle of `sdram_ack`, then drops.
- After completion (ack for a write, valid for a read), IDLE lasts 1 cycle before the next grant. Back-to-back writes therefore issue every (ack latency + 2) cycles.
- `reset` asserted mid-transaction: all registers return to reset values immediately. No ack or valid pulse is emitted for the aborted transaction.

## Configuration
- `SDRAM_ARB_ROUND_ROBIN_EN` defined: among eligible ports 1..3, the grant rotates. The search starts at the port after the last granted port, and the last-granted pointer resets to port 3. Port 0 keeps absolute priority.
- Not defined: fixed priority, where the lowest eligible index wins.

## Structure
- `tecmo_sdram_pkg` holds:
  - `SDRAM_ADDR_WIDTH` and `SDRAM_DATA_WIDTH`.
  - Port index constants `PORT_DOWNLOAD`=0, `PORT_MAIN`=1, `PORT_SOUND`=2, `PORT_GFX`=3.
  - The FSM state enum typedef `sdram_arb_state_t`.
- One combinational sub-module, `sdram_arb_pick`: it takes the eligible mask and the last-grant pointer and returns the next grant index and a `found` flag. It holds both the round-robin and the fixed-priority logic.

## Test plan
- Single read: port 1 requests addr 0x000100; controller acks after 2 cycles and returns valid 3 cycles later with 0xDEADBEEF. Required: `sdram_req` high 1 cycle after `port_req`, `port_ack[1]` pulses once, `port_valid[1]` pulses once with `port_q`=0xDEADBEEF, and no pulse appears on any other port.
- Download lock: `download`=1, ports 0–3 all requesting, port 0 writing 0x12345678 to 0x000000. Required: only port 0 is granted until `download` falls, with `sdram_we`=1 and `sdram_data`=0x12345678.
- Round robin (macro defined): ports 1, 2 and 3 hold requests continuously. Required: grant order 1,2,3,1,2,3. With the macro undefined: the grant order is 1,1,1.
- Ack and valid in the same cycle on a read from port 3. Required: `port_ack[3]` and `port_valid[3]` pulse together, and the FSM is back in IDLE on the next cycle.
- Reset mid-read (in WAIT_VALID). Required: `sdram_req`=0 and `grant`=0; a later `sdram_valid` produces no `port_valid` pulse.
- Requester drops its request early: port 2 drops `port_req` in REQ and changes its addr. Required: `sdram_addr` keeps the latched value and `port_ack[2]` still pulses.

Source files
------------

// File: rtl/tecmo_sdram_pkg.sv
// Shared widths, port indices and FSM state type for the SDRAM port arbiter.
package tecmo_sdram_pkg;

  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;

  localparam int PORT_DOWNLOAD = 0;
  localparam int PORT_MAIN     = 1;
  localparam int PORT_SOUND    = 2;
  localparam int PORT_GFX      = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT_VALID = 2'd2
  } sdram_arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Grant selection: port 0 has absolute priority; ports 1..N-1 are picked by
// rotation after last_i when SDRAM_ARB_ROUND_ROBIN_EN is defined, else lowest index wins.
module sdram_arb_pick
  import tecmo_sdram_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] elig_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [IDX_W-1:0]     grant_o,
  output logic                 found_o
);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  int idx;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx     = 0;
    if (elig_i[PORT_DOWNLOAD]) begin
      grant_o = IDX_W'(PORT_DOWNLOAD);
      found_o = 1'b1;
    end else begin
      // Walk ports 1..N-1 starting just after the last one served, wrapping past port 0.
      for (int off = 1; off < NUM_PORTS; off++) begin
        idx = int'(last_i) + off;
        if (idx >= NUM_PORTS) idx = idx - (NUM_PORTS - 1);
        if (!found_o && elig_i[IDX_W'(idx)]) begin
          grant_o = IDX_W'(idx);
          found_o = 1'b1;
        end
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!found_o && elig_i[IDX_W'(p)]) begin
        grant_o = IDX_W'(p);
        found_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/tecmo_sdram_arbiter.sv
// Shares one SDRAM controller port between download, main CPU, sound CPU and gfx clients.
// Optional rotating grant among ports 1..3: define SDRAM_ARB_ROUND_ROBIN_EN.
module tecmo_sdram_arbiter
  import tecmo_sdram_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter  int DATA_WIDTH = SDRAM_DATA_WIDTH,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 download,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data,
  input  logic [NUM_PORTS-1:0]                 port_we,
  input  logic [NUM_PORTS-1:0]                 port_req,
  output logic [NUM_PORTS-1:0]                 port_ack,
  output logic [NUM_PORTS-1:0]                 port_valid,
  output logic [DATA_WIDTH-1:0]                port_q,
  output logic [ADDR_WIDTH-1:0]                sdram_addr,
  output logic [DATA_WIDTH-1:0]                sdram_data,
  output logic                                 sdram_we,
  output logic                                 sdram_req,
  input  logic                                 sdram_ack,
  input  logic                                 sdram_valid,
  input  logic [DATA_WIDTH-1:0]                sdram_q,
  output sdram_arb_state_t                     dbg_state,
  output logic [IDX_W-1:0]                     dbg_grant
);

  // Handshake: a client holds port_req until its one-cycle port_ack; sdram_req
  // stays high through the cycle sdram_ack is seen; read data is valid only in
  // the single cycle port_valid pulses, and port_q carries sdram_q unregistered.

  sdram_arb_state_t       state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       last_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   we_q;
  logic                   req_q;

  logic [NUM_PORTS-1:0]   elig;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   unused_ignored;

  assign unused_ignored = ^{port_we[NUM_PORTS-1:1], port_data[NUM_PORTS-1:1]};

  // Port 0 may read or write, so its request alone makes it eligible.
  always_comb begin
    elig = port_req;
    if (download) begin
      elig                = '0;
      elig[PORT_DOWNLOAD] = port_req[PORT_DOWNLOAD];
    end
  end

  sdram_arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .elig_i  (elig),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .found_o (pick_found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(PORT_GFX);
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            addr_q  <= port_addr[pick_idx];
            if (pick_idx == IDX_W'(PORT_DOWNLOAD)) begin
              data_q <= port_data[PORT_DOWNLOAD];
              we_q   <= port_we[PORT_DOWNLOAD];
            end else begin
              data_q <= '0;
              we_q   <= 1'b0;
              last_q <= pick_idx;
            end
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            req_q <= 1'b0;
            if (we_q || sdram_valid) state_q <= IDLE;
            else                     state_q <= WAIT_VALID;
          end
        end
        WAIT_VALID: begin
          if (sdram_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    port_ack   = '0;
    port_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_ack[i]   = sdram_ack && (state_q == REQ) && (grant_q == IDX_W'(i));
      port_valid[i] = sdram_valid && (grant_q == IDX_W'(i)) &&
                      (((state_q == REQ) && sdram_ack && !we_q) || (state_q == WAIT_VALID));
    end
  end

  assign port_q     = sdram_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign sdram_we   = we_q;
  assign sdram_req  = req_q;
  assign dbg_state  = state_q;
  assign dbg_grant  = grant_q;

endmodule

// File: tb/tb_tecmo_sdram_arbiter.sv
// Randomised and directed bench for tecmo_sdram_arbiter with a queue scoreboard.
module tb_tecmo_sdram_arbiter;
  import tecmo_sdram_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              download;
  logic [3:0][22:0]  port_addr;
  logic [3:0][31:0]  port_data;
  logic [3:0]        port_we;
  logic [3:0]        port_req;
  logic [3:0]        port_ack;
  logic [3:0]        port_valid;
  logic [31:0]       port_q;
  logic [22:0]       sdram_addr;
  logic [31:0]       sdram_data;
  logic              sdram_we;
  logic              sdram_req;
  logic              sdram_ack;
  logic              sdram_valid;
  logic [31:0]       sdram_q;
  sdram_arb_state_t  dbg_state;
  logic [1:0]        dbg_grant;

  int total = 0;
  int bad   = 0;
  int last_m = 3;
  logic [3:0] hold_m = 4'b0000;
  logic req_prev = 1'b0;

  logic [55:0] exp_iss_q[$];  // {addr, data, we}
  logic [3:0]  exp_ack_q[$];  // one-hot port
  logic [35:0] exp_val_q[$];  // {one-hot port, data}

  tecmo_sdram_arbiter dut (
    .clk(clk), .reset(reset), .download(download),
    .port_addr(port_addr), .port_data(port_data), .port_we(port_we), .port_req(port_req),
    .port_ack(port_ack), .port_valid(port_valid), .port_q(port_q),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .sdram_q(sdram_q),
    .dbg_state(dbg_state), .dbg_grant(dbg_grant)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    port_req = '0;
    download = 1'b0;
    sdram_ack = 1'b0;
    sdram_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_m = 3;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event want event at %0t", name, $time);
  endtask

  // Reference grant rule: download locks to port 0, port 0 otherwise first,
  // then either rotation after the last served client or lowest index.
  function automatic int model_pick(input logic [3:0] req, input logic dl, input int last);
    if (dl) return req[0] ? 0 : -1;
    if (req[0]) return 0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k - 1) % 3 + 1;
      if (req[c]) return c;
    end
`else
    for (int c = 1; c <= 3; c++) if (req[c]) return c;
`endif
    return -1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [55:0] ei;
    logic [35:0] ev;
    logic [3:0]  ea;
    if (!reset) begin
      if (sdram_req && !req_prev) begin
        if (exp_iss_q.size() == 0) fail_now("issue_unexpected");
        else begin
          ei = exp_iss_q.pop_front();
          check("issue_addr", 64'(sdram_addr), 64'(ei[55:33]));
          check("issue_we", 64'(sdram_we), 64'(ei[0]));
          if (ei[0]) check("issue_data", 64'(sdram_data), 64'(ei[32:1]));
        end
      end
      if (port_ack != 4'b0) begin
        if (exp_ack_q.size() == 0) check("ack_stray", 64'(port_ack), 64'(0));
        else begin
          ea = exp_ack_q.pop_front();
          check("port_ack", 64'(port_ack), 64'(ea));
        end
      end
      if (port_valid != 4'b0) begin
        if (exp_val_q.size() == 0) check("valid_stray", 64'(port_valid), 64'(0));
        else begin
          ev = exp_val_q.pop_front();
          check("port_valid", 64'(port_valid), 64'(ev[35:32]));
          check("port_q", 64'(port_q), 64'(ev[31:0]));
        end
      end
    end
    req_prev = sdram_req;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!sdram_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = sdram_req;
    if (!ok) fail_now("req_timeout");
  endtask

  // One transaction: the model predicts the winner, the bench plays the controller.
  task automatic serve(input int ack_lat, input int val_lat, input bit early_drop, input logic [31:0] q);
    int p;
    int al;
    int vl;
    logic [22:0] a;
    logic we;
    bit ok;
    p = model_pick(port_req, download, last_m);
    if (p < 0) begin
      fail_now("model_no_request");
      return;
    end
    a  = port_addr[p];
    we = (p == 0) ? port_we[0] : 1'b0;
    exp_iss_q.push_back({a, (we ? port_data[p] : 32'h0), we});
    exp_ack_q.push_back(4'(1 << p));
    if (!we) exp_val_q.push_back({4'(1 << p), q});
    if (p != 0) last_m = p;
    wait_req(ok);
    if (!ok) return;
    if (early_drop) begin
      port_req[p]  = 1'b0;
      port_addr[p] = ~a;
    end
    al = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
    vl = (val_lat < 0) ? int'($urandom_range(0, 3)) : val_lat;
    repeat (al) begin
      @(posedge clk);
      #1;
    end
    if (early_drop) check("addr_hold", 64'(sdram_addr), 64'(a));
    sdram_ack = 1'b1;
    if (!we && vl == 0) begin
      sdram_valid = 1'b1;
      sdram_q = q;
    end
    @(posedge clk);
    #1;
    sdram_ack = 1'b0;
    sdram_valid = 1'b0;
    if (!hold_m[p]) port_req[p] = 1'b0;
    if (!we && vl != 0) begin
      repeat (vl - 1) begin
        @(posedge clk);
        #1;
      end
      sdram_valid = 1'b1;
      sdram_q = q;
      @(posedge clk);
      #1;
      sdram_valid = 1'b0;
    end
  endtask

  task automatic new_req(input int p, input logic wr);
    logic [1:0] pb;
    pb = p[1:0];
    port_addr[p] = {pb, 21'($urandom)};
    port_data[p] = $urandom;
    port_we[p]   = wr;
    port_req[p]  = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    port_addr = '0;
    port_data = '0;
    port_we = '0;
    sdram_q = '0;
    do_reset();

    // reset values
    check("rst_req", 64'(sdram_req), 64'(0));
    check("rst_we", 64'(sdram_we), 64'(0));
    check("rst_addr", 64'(sdram_addr), 64'(0));
    check("rst_data", 64'(sdram_data), 64'(0));
    check("rst_ack", 64'(port_ack), 64'(0));
    check("rst_valid", 64'(port_valid), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_grant", 64'(dbg_grant), 64'(0));

    // single read on port 1
    port_addr[1] = 23'h000100;
    port_we[1] = 1'b0;
    port_req[1] = 1'b1;
    @(posedge clk);
    #1;
    check("req_latency", 64'(sdram_req), 64'(1));
    serve(2, 3, 1'b0, 32'hDEADBEEF);

    // stray controller strobes in IDLE
    sdram_ack = 1'b1;
    sdram_valid = 1'b1;
    #1;
    check("idle_strobe", 64'({port_ack, port_valid}), 64'(0));
    @(posedge clk);
    #1;
    sdram_ack = 1'b0;
    sdram_valid = 1'b0;
    check("idle_stays", 64'(dbg_state), 64'(IDLE));

    // download lock: only port 0 while download is high
    port_addr[0] = 23'h000000;
    port_data[0] = 32'h12345678;
    port_we[0] = 1'b1;
    port_req = 4'b1111;
    for (int p = 1; p < 4; p++) port_we[p] = 1'b0;
    download = 1'b1;
    hold_m = 4'b0001;
    repeat (3) serve(-1, -1, 1'b0, $urandom);
    download = 1'b0;
    port_req[0] = 1'b0;
    hold_m = 4'b0000;
    repeat (3) serve(-1, -1, 1'b0, $urandom);

    // continuous requests on 1..3 from a fresh pointer
    do_reset();
    for (int p = 1; p < 4; p++) new_req(p, 1'b0);
    hold_m = 4'b1110;
    repeat (6) serve(1, -1, 1'b0, $urandom);
    hold_m = 4'b0000;
    port_req = '0;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    // ack and valid together on port 3
    new_req(3, 1'b0);
    serve(1, 0, 1'b0, $urandom);
    check("same_cycle_idle", 64'(dbg_state), 64'(IDLE));

    // early drop: port 2 withdraws and changes address while in REQ
    new_req(2, 1'b0);
    serve(2, 1, 1'b1, $urandom);

    // reset while waiting for read data
    new_req(2, 1'b0);
    exp_iss_q.push_back({port_addr[2], 32'h0, 1'b0});
    exp_ack_q.push_back(4'b0100);
    wait_req(ok);
    @(posedge clk);
    #1;
    sdram_ack = 1'b1;
    @(posedge clk);
    #1;
    sdram_ack = 1'b0;
    port_req[2] = 1'b0;
    check("mid_state", 64'(dbg_state), 64'(WAIT_VALID));
    reset = 1'b1;
    #1;
    check("abort_req", 64'(sdram_req), 64'(0));
    check("abort_grant", 64'(dbg_grant), 64'(0));
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_m = 3;
    sdram_valid = 1'b1;
    sdram_q = $urandom;
    #1;
    check("abort_valid", 64'(port_valid), 64'(0));
    @(posedge clk);
    #1;
    sdram_valid = 1'b0;

    // randomised traffic
    for (int it = 0; it < 40; it++) begin
      download = ($urandom_range(0, 4) == 0);
      for (int p = 0; p < 4; p++)
        if (!port_req[p] && $urandom_range(0, 1) == 1) new_req(p, 1'($urandom_range(0, 1)));
      if (download && !port_req[0]) new_req(0, 1'($urandom_range(0, 1)));
      if (port_req == 4'b0) new_req(1, 1'b0);
      serve(-1, -1, 1'b0, $urandom);
    end
    download = 1'b0;
    port_req = '0;

    repeat (5) @(posedge clk);
    #1;
    check("issue_left", 64'(exp_iss_q.size()), 64'(0));
    check("ack_left", 64'(exp_ack_q.size()), 64'(0));
    check("valid_left", 64'(exp_val_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
